reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular reorder buffer for the Tomasulo core.
- Allocates rename tags at issue and captures results from the common data bus (CDB).
- Commits results in program order to the register file, one per cycle.
- On a committed mispredicted branch, flushes itself and drives the pipeline-wide clear with a redirect PC.

Parameters:
DEPTH, 16, number of ROB entries (power of two)
TAG_WIDTH, 5, tag width; tag = entry index + 1, tag 0 = empty tag; DEPTH <= 2^TAG_WIDTH - 1
REG_WIDTH, 5, architectural register index width
DATA_WIDTH, 32, data and PC width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
rdy  input  1  global ready; low freezes all state
issue_valid  input  1  decoder requests an entry
issue_rd  input  REG_WIDTH  destination register (0 = none)
rob_full  output  1  no free entry (count == DEPTH)
alloc_tag  output  TAG_WIDTH  tag the next issue receives (tail+1), combinational
cdb_valid  input  1  result broadcast
cdb_tag  input  TAG_WIDTH  producing entry tag
cdb_data  input  DATA_WIDTH  result value
cdb_mispredict  input  1  entry is a mispredicted branch
cdb_target_pc  input  DATA_WIDTH  correct PC for a mispredict
query1_tag  input  TAG_WIDTH  operand tag lookup 1
query1_ready  output  1  value for query1_tag available
query1_data  output  DATA_WIDTH  value for query1_tag
query2_tag  input  TAG_WIDTH  operand tag lookup 2
query2_ready  output  1  value for query2_tag available
query2_data  output  DATA_WIDTH  value for query2_tag
commit_valid  output  1  commit pulse to the register file
commit_rd  output  REG_WIDTH  committed destination register
commit_data  output  DATA_WIDTH  committed value
commit_tag  output  TAG_WIDTH  committed tag; register file clears its tag only on match
clear  output  1  one-cycle flush of the whole pipeline
clear_pc  output  DATA_WIDTH  redirect PC, valid while clear = 1

Behaviour:
- Per-entry state: busy, ready, rd, data, mispredict, target_pc. Pointers: head, tail. Counter: count (0..DEPTH).
- Reset (rst = 1 at posedge): all entries idle; head = tail = count = 0. All registered outputs = 0: commit_valid, commit_rd, commit_data, commit_tag, clear, clear_pc. Reset overrides rdy.
- rdy = 0: no state change. Registered outputs hold their values, except commit_valid and clear, which are forced to 0.
- Issue:
  - Occurs when issue_valid && !rob_full && !clear_pending && rdy.
  - Entry[tail] gets busy = 1, ready = 0, mispredict = 0, rd = issue_rd. tail wraps modulo DEPTH.
  - issue_rd = 0 still allocates an entry.
- Writeback:
  - When cdb_valid and entry[cdb_tag-1] is busy: set ready = 1 and latch data, mispredict, target_pc.
  - cdb_tag = 0 is ignored. A CDB hit to a non-busy entry is ignored.
- Commit:
  - Occurs when entry[head] is busy and ready (registered state, not the same-cycle CDB).
  - Next cycle: commit_valid = 1 with that entry's rd, data and tag (index+1). Free the entry; head wraps.
  - commit_valid is 0 in every cycle without a commit. Throughput is at most one commit per cycle; commit latency is 1 cycle after ready is set.
- Mispredict commit:
  - The entry commits normally (link value written), and clear = 1 with clear_pc = target_pc in the same cycle as that commit_valid.
  - In the commit cycle, all entries are invalidated and head = tail = count = 0. Any issue in that cycle is dropped (clear_pending).
  - clear lasts exactly one cycle.
- Count and full:
  - count += issue, -= commit; simultaneous issue and commit leaves count unchanged.
  - rob_full = (count == DEPTH), taken from registered count. An issue is refused when full even if a commit occurs in the same cycle.
- Query (combinational), applied independently for each port:
  - tag 0 → ready = 1, data = 0.
  - Entry busy and ready → ready = 1, data = entry data.
  - Else cdb_valid && cdb_tag == query tag → ready = 1, data = cdb_data.
  - Else ready = 0, data = 0.
- Wrap-around: head and tail wrap independently. full vs empty is distinguished only by count.

Test Plan:
- Reset, then issue rd = 3, 5, 7 → alloc_tag 1, 2, 3; CDB tag 2 data 0xAA, then tag 1 data 0x11, then tag 3 data 0x33 → commits in order (3, 0x11, tag 1), (5, 0xAA, tag 2), (7, 0x33, tag 3), one per cycle.
- Issue 16 entries → rob_full = 1 and a 17th issue is ignored. Write back and commit entry 1 → rob_full = 0 the next cycle. Next issue gets alloc_tag 1 (wrap).
- Issue tags 1–4, mispredict on tag 2 with target 0x100, all ready → commit tag 1, then tag 2 with clear = 1, clear_pc = 0x100. Tags 3 and 4 never commit; alloc_tag returns to 1.
- query1_tag = 4 while cdb_valid with tag 4, data 0x55 → query1_ready = 1, query1_data = 0x55 in the same cycle; query2_tag = 0 → ready = 1, data = 0.
- rdy = 0 for 3 cycles with a ready head → no commit_valid, head unchanged; commit occurs on the first cycle after rdy = 1.
- rst asserted with 5 busy entries → next cycle count = 0, rob_full = 0, commit_valid = 0, clear = 0, alloc_tag = 1.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates rename tags at issue, captures CDB results,
// commits in program order and flushes the pipeline on a committed mispredict.
module reorder_buffer #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned TAG_WIDTH  = 5,
    parameter int unsigned REG_WIDTH  = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  issue_valid,
    input  logic [REG_WIDTH-1:0]  issue_rd,
    output logic                  rob_full,
    output logic [TAG_WIDTH-1:0]  alloc_tag,
    input  logic                  cdb_valid,
    input  logic [TAG_WIDTH-1:0]  cdb_tag,
    input  logic [DATA_WIDTH-1:0] cdb_data,
    input  logic                  cdb_mispredict,
    input  logic [DATA_WIDTH-1:0] cdb_target_pc,
    input  logic [TAG_WIDTH-1:0]  query1_tag,
    output logic                  query1_ready,
    output logic [DATA_WIDTH-1:0] query1_data,
    input  logic [TAG_WIDTH-1:0]  query2_tag,
    output logic                  query2_ready,
    output logic [DATA_WIDTH-1:0] query2_data,
    output logic                  commit_valid,
    output logic [REG_WIDTH-1:0]  commit_rd,
    output logic [DATA_WIDTH-1:0] commit_data,
    output logic [TAG_WIDTH-1:0]  commit_tag,
    output logic                  clear,
    output logic [DATA_WIDTH-1:0] clear_pc
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Per-entry state
    logic [DEPTH-1:0]      r_busy;
    logic [DEPTH-1:0]      r_ready;
    logic [DEPTH-1:0]      r_mis;
    logic [REG_WIDTH-1:0]  r_rd   [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DATA_WIDTH-1:0] r_tpc  [DEPTH];

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;

    logic                  r_commit_valid;
    logic [REG_WIDTH-1:0]  r_commit_rd;
    logic [DATA_WIDTH-1:0] r_commit_data;
    logic [TAG_WIDTH-1:0]  r_commit_tag;
    logic                  r_clear;
    logic [DATA_WIDTH-1:0] r_clear_pc;

    logic          w_commit;
    logic          w_flush;
    logic          w_issue;
    logic          w_cdb_hit;
    logic [PW-1:0] w_cdb_idx;
    logic [PW:0]   w_count_next;

    assign rob_full  = (r_count == (PW + 1)'(DEPTH));
    assign alloc_tag = TAG_WIDTH'(r_tail) + TAG_WIDTH'(1);

    // Control decode: commit from registered state; a flushing commit drops any issue
    always_comb begin
        w_commit  = rdy && r_busy[r_head] && r_ready[r_head];
        w_flush   = w_commit && r_mis[r_head];
        w_issue   = rdy && issue_valid && !rob_full && !w_flush;
        w_cdb_idx = PW'(cdb_tag - TAG_WIDTH'(1));
        w_cdb_hit = cdb_valid && (cdb_tag != '0) && (cdb_tag <= TAG_WIDTH'(DEPTH))
                    && r_busy[w_cdb_idx];
        w_count_next = r_count;
        if (w_issue && !w_commit) begin
            w_count_next = r_count + (PW + 1)'(1);
        end else if (!w_issue && w_commit) begin
            w_count_next = r_count - (PW + 1)'(1);
        end
    end

    // Entry flags and pointers; later assignments (commit free, flush) take priority
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_ready <= '0;
            r_mis   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (w_cdb_hit) begin
                r_ready[w_cdb_idx] <= 1'b1;
                r_mis[w_cdb_idx]   <= cdb_mispredict;
            end
            if (w_issue) begin
                r_busy[r_tail]  <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_mis[r_tail]   <= 1'b0;
                r_tail          <= r_tail + PW'(1);
            end
            if (w_commit) begin
                r_busy[r_head]  <= 1'b0;
                r_ready[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            r_count <= w_count_next;
            if (w_flush) begin
                r_busy  <= '0;
                r_ready <= '0;
                r_mis   <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end
        end
    end

    // Entry payload; only meaningful while the matching busy/ready bits are set
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            if (w_cdb_hit) begin
                r_data[w_cdb_idx] <= cdb_data;
                r_tpc[w_cdb_idx]  <= cdb_target_pc;
            end
            if (w_issue) begin
                r_rd[r_tail] <= issue_rd;
            end
        end
    end

    // Registered commit and clear outputs; pulses drop while rdy is low
    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_valid <= 1'b0;
            r_commit_rd    <= '0;
            r_commit_data  <= '0;
            r_commit_tag   <= '0;
            r_clear        <= 1'b0;
            r_clear_pc     <= '0;
        end else if (!rdy) begin
            r_commit_valid <= 1'b0;
            r_clear        <= 1'b0;
        end else begin
            r_commit_valid <= w_commit;
            r_clear        <= w_flush;
            if (w_commit) begin
                r_commit_rd   <= r_rd[r_head];
                r_commit_data <= r_data[r_head];
                r_commit_tag  <= TAG_WIDTH'(r_head) + TAG_WIDTH'(1);
            end
            if (w_flush) begin
                r_clear_pc <= r_tpc[r_head];
            end
        end
    end

    assign commit_valid = r_commit_valid;
    assign commit_rd    = r_commit_rd;
    assign commit_data  = r_commit_data;
    assign commit_tag   = r_commit_tag;
    assign clear        = r_clear;
    assign clear_pc     = r_clear_pc;

    // Operand lookup: {ready, data}; stored result wins over a same-cycle CDB broadcast
    function automatic logic [DATA_WIDTH:0] f_query(input logic [TAG_WIDTH-1:0] tag);
        logic [PW-1:0] idx;
        logic          in_range;
        idx      = PW'(tag - TAG_WIDTH'(1));
        in_range = (tag <= TAG_WIDTH'(DEPTH));
        if (tag == '0) begin
            return {1'b1, {DATA_WIDTH{1'b0}}};
        end else if (in_range && r_busy[idx] && r_ready[idx]) begin
            return {1'b1, r_data[idx]};
        end else if (cdb_valid && (cdb_tag == tag)) begin
            return {1'b1, cdb_data};
        end
        return '0;
    endfunction

    // Both query ports resolved independently
    always_comb begin
        {query1_ready, query1_data} = f_query(query1_tag);
        {query2_ready, query2_data} = f_query(query2_tag);
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: commit scoreboard plus query vector table.
module tb_reorder_buffer;

    localparam int DEPTH = 16;
    localparam int TW    = 5;
    localparam int RW    = 5;
    localparam int DW    = 32;

    logic          clk;
    logic          rst;
    logic          rdy;
    logic          issue_valid;
    logic [RW-1:0] issue_rd;
    logic          rob_full;
    logic [TW-1:0] alloc_tag;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic          cdb_mispredict;
    logic [DW-1:0] cdb_target_pc;
    logic [TW-1:0] query1_tag;
    logic          query1_ready;
    logic [DW-1:0] query1_data;
    logic [TW-1:0] query2_tag;
    logic          query2_ready;
    logic [DW-1:0] query2_data;
    logic          commit_valid;
    logic [RW-1:0] commit_rd;
    logic [DW-1:0] commit_data;
    logic [TW-1:0] commit_tag;
    logic          clear;
    logic [DW-1:0] clear_pc;

    reorder_buffer #(
        .DEPTH      (DEPTH),
        .TAG_WIDTH  (TW),
        .REG_WIDTH  (RW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .rob_full       (rob_full),
        .alloc_tag      (alloc_tag),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .cdb_mispredict (cdb_mispredict),
        .cdb_target_pc  (cdb_target_pc),
        .query1_tag     (query1_tag),
        .query1_ready   (query1_ready),
        .query1_data    (query1_data),
        .query2_tag     (query2_tag),
        .query2_ready   (query2_ready),
        .query2_data    (query2_data),
        .commit_valid   (commit_valid),
        .commit_rd      (commit_rd),
        .commit_data    (commit_data),
        .commit_tag     (commit_tag),
        .clear          (clear),
        .clear_pc       (clear_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic          clr;
        logic [DW-1:0] pc;
    } commit_t;

    typedef struct {
        logic [TW-1:0] q1;
        logic [TW-1:0] q2;
        logic          cv;
        logic [TW-1:0] ct;
        logic [DW-1:0] cd;
        logic          e1r;
        logic [DW-1:0] e1d;
        logic          e2r;
        logic [DW-1:0] e2d;
    } qvec_t;

    commit_t exp_q[$];
    commit_t mon_e;
    qvec_t   qv[7];
    int      n_checks = 0;
    int      n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every commit pulse must match the oldest expected commit
    always @(negedge clk) begin
        if (!rst) begin
            if (commit_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_commit: got tag %0d expected none", commit_tag);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("commit_rd", 64'(commit_rd), 64'(mon_e.rd));
                    check("commit_data", 64'(commit_data), 64'(mon_e.data));
                    check("commit_tag", 64'(commit_tag), 64'(mon_e.tag));
                    check("commit_clear", 64'(clear), 64'(mon_e.clr));
                    if (mon_e.clr) check("clear_pc", 64'(clear_pc), 64'(mon_e.pc));
                end
            end else if (clear) begin
                n_checks++;
                n_errors++;
                $display("FAIL clear_without_commit: got 1 expected 0");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_issue(input logic [RW-1:0] rd, input logic [TW-1:0] exp_tag);
        check("alloc_tag", 64'(alloc_tag), 64'(exp_tag));
        issue_valid = 1'b1;
        issue_rd    = rd;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic do_wb(input logic [TW-1:0] tag, input logic [DW-1:0] data,
                         input logic mis, input logic [DW-1:0] pc);
        cdb_valid      = 1'b1;
        cdb_tag        = tag;
        cdb_data       = data;
        cdb_mispredict = mis;
        cdb_target_pc  = pc;
        tick();
        cdb_valid      = 1'b0;
        cdb_mispredict = 1'b0;
    endtask

    task automatic push(input logic [RW-1:0] rd, input logic [DW-1:0] data,
                        input logic [TW-1:0] tag, input logic clr, input logic [DW-1:0] pc);
        commit_t e;
        e.rd = rd; e.data = data; e.tag = tag; e.clr = clr; e.pc = pc;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        qv[0] = '{q1: 4, q2: 0, cv: 1, ct: 4, cd: 32'h55, e1r: 1, e1d: 32'h55, e2r: 1, e2d: 0};
        qv[1] = '{q1: 3, q2: 2, cv: 0, ct: 0, cd: 0, e1r: 1, e1d: 32'h33, e2r: 0, e2d: 0};
        qv[2] = '{q1: 2, q2: 3, cv: 1, ct: 2, cd: 32'h99, e1r: 1, e1d: 32'h99, e2r: 1,
                  e2d: 32'h33};
        qv[3] = '{q1: 5, q2: 1, cv: 1, ct: 5, cd: 32'h12, e1r: 1, e1d: 32'h12, e2r: 0, e2d: 0};
        qv[4] = '{q1: 1, q2: 4, cv: 1, ct: 3, cd: 32'hEE, e1r: 0, e1d: 0, e2r: 0, e2d: 0};
        qv[5] = '{q1: 3, q2: 3, cv: 1, ct: 3, cd: 32'hEE, e1r: 1, e1d: 32'h33, e2r: 1,
                  e2d: 32'h33};
        qv[6] = '{q1: 0, q2: 0, cv: 0, ct: 0, cd: 0, e1r: 1, e1d: 0, e2r: 1, e2d: 0};

        rst = 1'b1; rdy = 1'b1; issue_valid = 1'b0; issue_rd = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; cdb_mispredict = 1'b0;
        cdb_target_pc = '0; query1_tag = '0; query2_tag = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_commit_valid", 64'(commit_valid), 64'd0);
        check("reset_clear", 64'(clear), 64'd0);
        check("reset_full", 64'(rob_full), 64'd0);
        check("reset_commit_tag", 64'(commit_tag), 64'd0);

        // In-order commit of out-of-order results
        do_issue(3, 1);
        do_issue(5, 2);
        do_issue(7, 3);
        push(3, 32'h11, 1, 0, 0);
        push(5, 32'hAA, 2, 0, 0);
        push(7, 32'h33, 3, 0, 0);
        do_wb(2, 32'hAA, 0, 0);
        do_wb(1, 32'h11, 0, 0);
        check("early_commit", 64'(commit_valid), 64'd0);
        do_wb(3, 32'h33, 0, 0);
        check("order_c1_tag", 64'(commit_tag), 64'd1);
        tick();
        check("order_c2_tag", 64'(commit_tag), 64'd2);
        tick();
        check("order_c3_tag", 64'(commit_tag), 64'd3);
        tick();
        check("order_idle", 64'(commit_valid), 64'd0);
        drain();

        // Fill, refuse on full, free one, wrap allocation
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_not_full", 64'(rob_full), 64'd0);
            do_issue(RW'(i), TW'(i + 1));
        end
        check("full_after_16", 64'(rob_full), 64'd1);
        check("alloc_wrapped", 64'(alloc_tag), 64'd1);
        issue_valid = 1'b1;
        issue_rd    = 5'd31;
        tick();
        issue_valid = 1'b0;
        check("full_after_17th", 64'(rob_full), 64'd1);
        check("alloc_after_17th", 64'(alloc_tag), 64'd1);
        push(0, 32'hC1, 1, 0, 0);
        do_wb(1, 32'hC1, 0, 0);
        check("full_before_commit", 64'(rob_full), 64'd1);
        tick();
        check("full_cleared_by_commit", 64'(commit_valid), 64'd1);
        check("not_full_after_commit", 64'(rob_full), 64'd0);
        do_issue(9, 1);
        check("full_again", 64'(rob_full), 64'd1);
        drain();

        // Mispredict flush, with an issue attempted in the flush cycle
        do_reset();
        for (int i = 0; i < 4; i++) do_issue(RW'(i + 1), TW'(i + 1));
        push(1, 32'h11, 1, 0, 0);
        push(2, 32'h22, 2, 1, 32'h100);
        do_wb(2, 32'h22, 1, 32'h100);
        do_wb(1, 32'h11, 0, 0);
        do_wb(3, 32'h33, 0, 0);
        check("pre_flush_alloc", 64'(alloc_tag), 64'd5);
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        do_wb(4, 32'h44, 0, 0);
        issue_valid = 1'b0;
        check("flush_clear", 64'(clear), 64'd1);
        check("flush_clear_pc", 64'(clear_pc), 64'h100);
        check("flush_commit_tag", 64'(commit_tag), 64'd2);
        check("flush_alloc", 64'(alloc_tag), 64'd1);
        check("flush_not_full", 64'(rob_full), 64'd0);
        tick();
        check("clear_one_cycle", 64'(clear), 64'd0);
        check("no_commit_after_flush", 64'(commit_valid), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        push(6, 32'h66, 1, 0, 0);
        do_issue(6, 1);
        do_wb(1, 32'h66, 0, 0);
        drain();

        // Query vector table, state frozen with rdy low so CDB drives cause no writes
        do_reset();
        for (int i = 0; i < 4; i++) do_issue(RW'(i + 1), TW'(i + 1));
        do_wb(3, 32'h33, 0, 0);
        rdy = 1'b0;
        for (int i = 0; i < 7; i++) begin
            query1_tag = qv[i].q1;
            query2_tag = qv[i].q2;
            cdb_valid  = qv[i].cv;
            cdb_tag    = qv[i].ct;
            cdb_data   = qv[i].cd;
            #1;
            check($sformatf("q1_ready_v%0d", i), 64'(query1_ready), 64'(qv[i].e1r));
            check($sformatf("q1_data_v%0d", i), 64'(query1_data), 64'(qv[i].e1d));
            check($sformatf("q2_ready_v%0d", i), 64'(query2_ready), 64'(qv[i].e2r));
            check($sformatf("q2_data_v%0d", i), 64'(query2_data), 64'(qv[i].e2d));
        end
        cdb_valid = 1'b0;
        tick();
        rdy = 1'b1;
        check("q_frozen_alloc", 64'(alloc_tag), 64'd5);

        // rdy low holds a ready head; commit on first cycle back
        do_reset();
        do_issue(9, 1);
        do_wb(1, 32'h99, 0, 0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_no_commit", 64'(commit_valid), 64'd0);
        end
        rdy = 1'b1;
        push(9, 32'h99, 1, 0, 0);
        tick();
        check("stall_release_commit", 64'(commit_valid), 64'd1);
        check("stall_release_tag", 64'(commit_tag), 64'd1);
        drain();

        // Reset with 5 busy entries, then exactly DEPTH issues fill it
        for (int i = 0; i < 5; i++) do_issue(RW'(i + 1), TW'(i + 2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst5_full", 64'(rob_full), 64'd0);
        check("rst5_commit_valid", 64'(commit_valid), 64'd0);
        check("rst5_clear", 64'(clear), 64'd0);
        check("rst5_alloc", 64'(alloc_tag), 64'd1);
        for (int i = 0; i < DEPTH - 1; i++) do_issue(RW'(i), TW'(i + 1));
        check("rst5_count_15", 64'(rob_full), 64'd0);
        do_issue(1, 16);
        check("rst5_count_16", 64'(rob_full), 64'd1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
